bus_rx_buffer: RTL and testbench

- Receiving end of the shared tristate data bus. Drivers place a word on the bus with a bus-valid strobe and a destination ID.
- This block snoops the bus and captures words addressed to its own ID into a small FIFO. It acknowledges each accepted transfer and back-pressures drivers when full.
- It presents captured words to a local consumer through a valid/ready interface.
- Sits between the bus fabric and a datapath unit, such as a register-file write port or the ALU operand latch.

---
 rtl/bus_rx_buffer.sv | 83 ++++++++
 tb/tb_bus_rx_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bus_rx_buffer.sv
// Bus receiver: snoops the shared bus, queues words addressed to MY_ID in a FWFT FIFO.
// Optional parity checking of incoming words is enabled with `define BUS_RX_PARITY_EN.
module bus_rx_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int ID_W  = 3,
  parameter int MY_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         bus_data,
  input  logic                     bus_valid,
  input  logic [ID_W-1:0]          bus_dest,
  input  logic                     bus_par,
  output logic                     bus_ack,
  output logic                     bus_busy,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     par_err,
  input  logic                     err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        hit, full, par_bad, push, pop;

  assign hit  = bus_valid && (bus_dest == ID_W'(MY_ID));
  assign full = (count == CW'(DEPTH));

`ifdef BUS_RX_PARITY_EN
  assign par_bad = ^{bus_data, bus_par};
`else
  logic unused_par;
  assign unused_par = bus_par;
  assign par_bad    = 1'b0;
`endif

  // Fullness is judged before any same-cycle pop, so a full FIFO never admits a word.
  assign push = hit && !full && !par_bad;
  assign pop  = out_valid && out_ready;

  assign bus_busy  = full;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus_ack  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      bus_ack <= push;
      // Set has priority over clear on the sticky flag.
      if (hit && full)  overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

`ifdef BUS_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)                 par_err <= 1'b0;
    else if (hit && par_bad) par_err <= 1'b1;
    else if (err_clr)        par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rx_buffer.sv
// Directed, table-driven bench for bus_rx_buffer (WIDTH=32, DEPTH=4, ID_W=3, MY_ID=0).
module tb_bus_rx_buffer;
  logic        clk = 1'b0;
  logic        rst, bus_valid, bus_par, out_ready, err_clr;
  logic [31:0] bus_data;
  logic [2:0]  bus_dest;
  logic        bus_ack, bus_busy, out_valid, overflow, par_err;
  logic [31:0] out_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  bus_rx_buffer #(.WIDTH(32), .DEPTH(4), .ID_W(3), .MY_ID(0)) dut (
    .clk(clk), .rst(rst), .bus_data(bus_data), .bus_valid(bus_valid),
    .bus_dest(bus_dest), .bus_par(bus_par), .bus_ack(bus_ack), .bus_busy(bus_busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .overflow(overflow), .par_err(par_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst, v;
    logic [2:0]  dest;
    logic [31:0] d;
    logic        bad, rdy, clr;
    logic        ack, oval;
    logic [2:0]  cnt;
    logic [31:0] od;
    logic        ovf, perr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string nm, logic r, logic v, logic [2:0] dest, logic [31:0] d,
                              logic bad, logic rdy, logic clr, logic ack, logic oval,
                              logic [2:0] cnt, logic [31:0] od, logic ovf, logic perr);
    vec_t x;
    x.nm = nm; x.rst = r; x.v = v; x.dest = dest; x.d = d; x.bad = bad; x.rdy = rdy;
    x.clr = clr; x.ack = ack; x.oval = oval; x.cnt = cnt; x.od = od; x.ovf = ovf; x.perr = perr;
    vq.push_back(x);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // bad=1 flips the parity bit away from even parity.
  task automatic drive(logic r, logic v, logic [2:0] dest, logic [31:0] d, logic bad,
                       logic rdy, logic clr);
    rst = r; bus_valid = v; bus_dest = dest; bus_data = d; bus_par = (^d) ^ bad;
    out_ready = rdy; err_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string nm, logic ack, logic oval, logic [2:0] cnt, logic [31:0] od,
                           logic ovf, logic perr);
    chk({nm, ".ack"},   32'(bus_ack),   32'(ack));
    chk({nm, ".valid"}, 32'(out_valid), 32'(oval));
    chk({nm, ".count"}, 32'(count),     32'(cnt));
    chk({nm, ".busy"},  32'(bus_busy),  32'(cnt == 3'd4));
    chk({nm, ".data"},  out_data,       od);
    chk({nm, ".ovf"},   32'(overflow),  32'(ovf));
    chk({nm, ".perr"},  32'(par_err),   32'(perr));
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    //   name       rst v dest data          bad rdy clr  ack val cnt out_data     ovf perr
    add("reset",    1, 0, 0, 32'h0,          0, 0, 0,    0, 0, 0, 32'h0,        0, 0);
    add("t1_push",  0, 1, 0, 32'hDEADBEEF,   0, 0, 0,    1, 1, 1, 32'hDEADBEEF, 0, 0);
    add("t1_hold",  0, 0, 0, 32'h0,          0, 0, 0,    0, 1, 1, 32'hDEADBEEF, 0, 0);
    add("t1_pop",   0, 0, 0, 32'h0,          0, 1, 0,    0, 0, 0, 32'h0,        0, 0);
    add("t2_a",     0, 1, 3, 32'h55,         0, 0, 0,    0, 0, 0, 32'h0,        0, 0);
    add("t2_b",     0, 1, 3, 32'h55,         0, 0, 0,    0, 0, 0, 32'h0,        0, 0);
    for (int k = 1; k <= 4; k++)
      add($sformatf("t3_p%0d", k), 0, 1, 0, 32'(k), 0, 0, 0, 1, 1, 3'(k), 32'h1, 0, 0);
    add("t3_full",  0, 1, 0, 32'h5,          0, 0, 0,    0, 1, 4, 32'h1,        1, 0);
    add("t3_d1",    0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 3, 32'h2,        1, 0);
    add("t3_d2",    0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 2, 32'h3,        1, 0);
    add("t3_d3",    0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 1, 32'h4,        1, 0);
    add("t3_d4",    0, 0, 0, 32'h0,          0, 1, 0,    0, 0, 0, 32'h1,        1, 0);
    add("t3_clr",   0, 0, 0, 32'h0,          0, 0, 1,    0, 0, 0, 32'h1,        0, 0);
    for (int k = 0; k < 3; k++)
      add($sformatf("t4_pre%0d", k), 0, 1, 0, 32'h10 + 32'(k), 0, 0, 0, 1, 1, 3'(k+1), 32'h10, 0, 0);
    for (int i = 0; i < 8; i++)
      add($sformatf("t4_wrap%0d", i), 0, 1, 0, 32'hA0 + 32'(i), 0, 1, 0, 1, 1, 3,
          (i == 0) ? 32'h11 : (i == 1) ? 32'h12 : 32'hA0 + 32'(i - 2), 0, 0);
    add("t4_dr1",   0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 2, 32'hA6,       0, 0);
    add("t4_dr2",   0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 1, 32'hA7,       0, 0);
    add("t4_dr3",   0, 0, 0, 32'h0,          0, 1, 0,    0, 0, 0, 32'hA4,       0, 0);
    for (int k = 0; k < 4; k++)
      add($sformatf("t5_fill%0d", k), 0, 1, 0, 32'hB0 + 32'(k), 0, 0, 0, 1, 1, 3'(k+1), 32'hB0, 0, 0);
    add("t5_setwin",0, 1, 0, 32'hB4,         0, 1, 1,    0, 1, 3, 32'hB1,       1, 0);
    add("t5_hold",  0, 0, 0, 32'h0,          0, 0, 0,    0, 1, 3, 32'hB1,       1, 0);
    add("t5_clr",   0, 0, 0, 32'h0,          0, 0, 1,    0, 1, 3, 32'hB1,       0, 0);
`ifdef BUS_RX_PARITY_EN
    add("par_word", 0, 1, 0, 32'h1,          1, 0, 0,    0, 1, 3, 32'hB1,       0, 1);
    add("par_pop",  0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 2, 32'hB2,       0, 1);
`else
    add("par_word", 0, 1, 0, 32'h1,          1, 0, 0,    1, 1, 4, 32'hB1,       0, 0);
    add("par_pop",  0, 0, 0, 32'h0,          0, 1, 0,    0, 1, 3, 32'hB2,       0, 0);
`endif
    add("t6_rst",   1, 1, 0, 32'h77,         0, 0, 0,    0, 0, 0, 32'h0,        0, 0);
    add("t6_post",  0, 0, 0, 32'h0,          0, 0, 0,    0, 0, 0, 32'h0,        0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v, vq[i].dest, vq[i].d, vq[i].bad, vq[i].rdy, vq[i].clr);
      tick();
      check_all(vq[i].nm, vq[i].ack, vq[i].oval, vq[i].cnt, vq[i].od, vq[i].ovf, vq[i].perr);
    end

    // Held bus_valid: each cycle is a distinct transfer; foreign ID while full is ignored.
    drive(1'b0, 1'b1, 3'd0, 32'hC0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus_data = 32'hC0 + 32'(k);
      bus_par  = ^bus_data;
      tick();
      chk($sformatf("hold_ack%0d", k), 32'(bus_ack), 32'd1);
    end
    chk("hold_count", 32'(count), 32'd4);
    drive(1'b0, 1'b1, 3'd5, 32'hEE, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("foreign_full", 1'b0, 1'b1, 3'd4, 32'hC0, 1'b0, 1'b0);
    // Reset while a matching word is on the bus and the FIFO is full.
    drive(1'b1, 1'b1, 3'd0, 32'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("rst_full", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst_after", 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
